// File: rtl/bsg_upstream_out_serializer.sv
// Upstream off-chip output serializer: buffers core words in a small FIFO and
// streams each one out as BEATS beats over CH parallel CH_W-bit channels.
module bsg_upstream_out_serializer #(
  parameter  int CORE_W     = 64,
  parameter  int CH         = 2,
  parameter  int CH_W       = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int BEAT_W     = CH * CH_W,
  localparam int BEATS      = CORE_W / BEAT_W,
  localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_valid_in,
  input  logic [CORE_W-1:0] core_data_in,
  output logic              core_ready_out,
  output logic              io_valid_out,
  output logic [BEAT_W-1:0] io_data_out,
  output logic              io_last_out,
  input  logic              io_ready,
  output logic [CW-1:0]     fifo_count
);

  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  logic [CORE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CORE_W-1:0] cur_q, cur_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              valid_q, valid_d;

  logic push, pop, adv, empty, last_beat;
  logic [CORE_W-1:0] head;

  // The ready path depends only on reset and the registered count, never on io_ready.
  assign core_ready_out = !rst && (count_q < FULL_CNT);
  assign push           = core_valid_in && core_ready_out;
  assign empty          = (count_q == '0);
  assign head           = mem[rd_ptr_q];
  assign last_beat      = (beat_q == LAST_BEAT);
  assign adv            = !valid_q || io_ready;

  assign io_valid_out = valid_q;
  assign io_last_out  = valid_q && last_beat;
  assign fifo_count   = count_q;

  // Beat mux: beat k carries slice k of the held word, channel 0 in the low bits.
  always_comb begin
    io_data_out = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_q == BW'(k)) begin
        io_data_out = cur_q[k*BEAT_W +: BEAT_W];
      end else begin
        io_data_out = io_data_out;
      end
    end
  end

  // Output stage: step through beats, reload from the FIFO head after the last one.
  always_comb begin
    cur_d   = cur_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    pop     = 1'b0;
    if (adv) begin
      if (valid_q && !last_beat) begin
        beat_d  = beat_q + BW'(1);
        valid_d = 1'b1;
      end else if (!empty) begin
        pop     = 1'b1;
        cur_d   = head;
        beat_d  = '0;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= core_data_in;
  end

  // State registers; reset discards any partial word and empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cur_q    <= '0;
      beat_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cur_q    <= cur_d;
      beat_q   <= beat_d;
      valid_q  <= valid_d;
    end
  end

endmodule
